// File: rtl/obstacle_scroller.sv
// Purpose : moves one pipe obstacle leftwards across the playfield and latches its gap height.
// Latency : frame_tick -> new x_out in 1 clk; respawn/passed are registered 1-clk pulses.
// Backpressure: none; run=0 freezes all state (pending ticks are dropped, not queued).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   frame_tick, run     per-frame step strobe, global run/freeze enable
//   speed               pixels per frame, sampled on the tick
//   height_in           height from the generator, clamped and latched as gap_y
//   x_out, gap_y        obstacle left edge and gap height for the current pass
//   visible             x_out is on screen
//   respawn, passed     1-clk pulses: reload to SPAWN_X, crossing of BIRD_X
module obstacle_scroller #(
  parameter int SCREEN_W    = 640,
  parameter int SPAWN_X     = 660,
  parameter int BIRD_X      = 100,
  parameter int HOLD_CYCLES = 4,
  parameter int START_Y     = 150,
  parameter int MIN_GAP_Y   = 100,
  parameter int MAX_GAP_Y   = 299
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic [3:0] speed,
  input  logic [9:0] height_in,
  output logic [9:0] x_out,
  output logic [9:0] gap_y,
  output logic       visible,
  output logic       respawn,
  output logic       passed
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SCROLL = 2'd2
  } state_t;

  localparam logic [9:0] SPAWN_X_V  = 10'(SPAWN_X);
  localparam logic [9:0] BIRD_X_V   = 10'(BIRD_X);
  localparam logic [9:0] SCREEN_W_V = 10'(SCREEN_W);
  localparam logic [9:0] START_Y_V  = 10'(START_Y);
  localparam logic [9:0] MIN_Y_V    = 10'(MIN_GAP_Y);
  localparam logic [9:0] MAX_Y_V    = 10'(MAX_GAP_Y);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);

  state_t     state;
  logic [3:0] hold_cnt;
  logic [9:0] height_clamped;
  logic [9:0] x_step;
  logic [9:0] speed_ext;

  assign visible   = (x_out < SCREEN_W_V);
  assign speed_ext = {6'd0, speed};
  assign x_step    = x_out - speed_ext;

  always_comb begin
    height_clamped = height_in;
    if (height_in < MIN_Y_V) begin
      height_clamped = MIN_Y_V;
    end else if (height_in > MAX_Y_V) begin
      height_clamped = MAX_Y_V;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      x_out    <= SPAWN_X_V;
      gap_y    <= START_Y_V;
      hold_cnt <= 4'd0;
      respawn  <= 1'b0;
      passed   <= 1'b0;
    end else begin
      // Pulses default low so they are exactly one clk wide.
      respawn <= 1'b0;
      passed  <= 1'b0;
      if (run) begin
        case (state)
          IDLE: begin
            state    <= HOLD;
            hold_cnt <= 4'd0;
          end
          HOLD: begin
            // Holding at SPAWN_X gives the generator time to produce a new height.
            if (hold_cnt == HOLD_LAST) begin
              gap_y    <= height_clamped;
              state    <= SCROLL;
              hold_cnt <= 4'd0;
            end else begin
              hold_cnt <= hold_cnt + 4'd1;
            end
          end
          SCROLL: begin
            if (frame_tick && (speed != 4'd0)) begin
              if (x_out >= speed_ext) begin
                x_out  <= x_step;
                passed <= (x_out >= BIRD_X_V) && (x_step < BIRD_X_V);
              end else begin
                // Step would wrap below zero: send the obstacle back to the spawn column.
                x_out    <= SPAWN_X_V;
                respawn  <= 1'b1;
                passed   <= (x_out >= BIRD_X_V);
                state    <= HOLD;
                hold_cnt <= 4'd0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
